if_fetch_stage: RTL and testbench

Instruction fetch stage of the in-order RV32 pipeline. It sits directly upstream of the instruction field decoder. It owns the program counter and issues in-order requests to instruction memory over a valid/ready channel. It buffers up to two fetched instructions and presents one `{pc, instruction}` pair per cycle to decode over a valid/ready handshake. It accepts redirects (branch, jump or trap targets) from later stages and discards wrong-path fetches, including ones still in flight in memory.

---
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32 instruction fetch stage: owns the PC, issues in-order imem requests, buffers up to two
// fetched instructions for decode and drops wrong-path responses after a redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  logic [31:0]       pc_q, pc_d;
  logic [1:0][31:0]  ent_pc_q, ent_pc_d;
  logic [1:0][31:0]  ent_instr_q, ent_instr_d;
  logic [1:0]        ent_filled_q, ent_filled_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        alloc_cnt_q, alloc_cnt_d;
  logic [1:0]        drop_cnt_q, drop_cnt_d;

  logic              deq;
  logic              alloc;
  logic              fill_idx;
  logic [1:0]        filled_cnt;
  logic [1:0]        unfilled_cnt;
  logic [2:0]        drop_raw;
  logic [1:0]        drop_redir;

  function automatic logic [1:0] sat_drop(input logic [2:0] v);
    return (v > 3'd2) ? 2'd2 : v[1:0];
  endfunction

  always_comb begin
    id_valid       = ent_filled_q[head_q] & ~redirect_valid;
    deq            = id_valid & id_ready;
    imem_req_valid = rst_n & ((alloc_cnt_q < 2'd2) | deq) & (drop_cnt_q == 2'd0) & ~redirect_valid;
    alloc          = imem_req_valid & imem_req_ready;
    imem_req_addr  = pc_q;
    id_instruction = id_valid ? ent_instr_q[head_q] : NOP_INSTR;
    id_pc          = id_valid ? ent_pc_q[head_q] : 32'h0;
  end

  // Filled entries always form a prefix starting at head, so the oldest unfilled slot is
  // either head or the one after it.
  always_comb begin
    filled_cnt   = {1'b0, ent_filled_q[0]} + {1'b0, ent_filled_q[1]};
    unfilled_cnt = alloc_cnt_q - filled_cnt;
    fill_idx     = ent_filled_q[head_q] ? ~head_q : head_q;
    drop_raw     = {1'b0, drop_cnt_q} + {1'b0, unfilled_cnt};
    if (imem_rsp_valid && (drop_raw != 3'd0)) begin
      drop_raw = drop_raw - 3'd1;
    end
    drop_redir   = sat_drop(drop_raw);
  end

  always_comb begin
    pc_d         = pc_q;
    ent_pc_d     = ent_pc_q;
    ent_instr_d  = ent_instr_q;
    ent_filled_d = ent_filled_q;
    head_d       = head_q;
    tail_d       = tail_q;
    alloc_cnt_d  = alloc_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ent_filled_d = 2'b00;
      head_d       = 1'b0;
      tail_d       = 1'b0;
      alloc_cnt_d  = 2'd0;
      drop_cnt_d   = drop_redir;
    end else begin
      if (deq) begin
        ent_filled_d[head_q] = 1'b0;
        head_d               = ~head_q;
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_q != 2'd0) begin
          drop_cnt_d = drop_cnt_q - 2'd1;
        end else if (unfilled_cnt != 2'd0) begin
          ent_instr_d[fill_idx]  = imem_rsp_data;
          ent_filled_d[fill_idx] = 1'b1;
        end
      end
      // The tail slot is free (or being freed by deq), never the fill target.
      if (alloc) begin
        ent_pc_d[tail_q]     = pc_q;
        ent_filled_d[tail_q] = 1'b0;
        tail_d               = ~tail_q;
        pc_d                 = pc_q + 32'd4;
      end
      alloc_cnt_d = alloc_cnt_q + {1'b0, alloc} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ent_filled_q <= 2'b00;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      alloc_cnt_q  <= 2'd0;
      drop_cnt_q   <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      ent_filled_q <= ent_filled_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      alloc_cnt_q  <= alloc_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Entry payloads are qualified by the filled bits, so they carry no reset.
  always_ff @(posedge clk) begin
    ent_pc_q    <= ent_pc_d;
    ent_instr_q <= ent_instr_d;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order latency memory model, expected-PC scoreboard,
// directed timing scenarios and a randomized phase with redirects.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat_min = 1;
  int lat_max = 1;
  int deq_count = 0;

  logic [31:0] model_pc;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: returns requests in order once their due cycle is reached, one per cycle.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (rst_n && (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr_q[0]);
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
    end
  end

  // Reference model: tracks the architectural fetch PC and the PCs owed to decode.
  initial begin
    int due;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_pc = RESET_PC;
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
      end else if (redirect_valid) begin
        check1("redirect_no_req", imem_req_valid, 1'b0);
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, model_pc);
        exp_q.push_back(model_pc);
        due = cyc + int'($urandom_range(lat_min, lat_max));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(due);
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: pops the scoreboard on every decode handshake.
  initial begin
    logic        stall_pending;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] e;
    stall_pending = 1'b0;
    held_pc = 32'h0;
    held_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending && !redirect_valid) begin
          check1("stall_valid_hold", id_valid, 1'b1);
          check("stall_pc_hold", id_pc, held_pc);
          check("stall_instr_hold", id_instruction, held_instr);
        end
        stall_pending = 1'b0;
        if (redirect_valid) check1("redirect_no_id", id_valid, 1'b0);
        if (!id_valid) begin
          check("idle_instr_nop", id_instruction, NOP);
          check("idle_pc_zero", id_pc, 32'h0);
        end else if (id_ready) begin
          deq_count++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL id_unexpected: got pc 0x%08h expected no instruction", id_pc);
          end else begin
            e = exp_q.pop_front();
            check("id_pc", id_pc, e);
            check("id_instr", id_instruction, mem_word(e));
          end
        end else begin
          stall_pending = 1'b1;
          held_pc       = id_pc;
          held_instr    = id_instruction;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instruction, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_id(input string name, input logic [31:0] exp_pc, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (id_valid) begin
        check(name, id_pc, exp_pc);
        return;
      end
      tick();
    end
    tests++;
    fails++;
    $display("FAIL %s: no id_valid within %0d cycles, expected pc 0x%08h", name, budget, exp_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int deq_before;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;

    // Reset, then streaming with single-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check1("stream_req_valid", imem_req_valid, 1'b1);
      check("stream_req_addr", imem_req_addr, 32'(4 * c));
      check1("stream_id_valid", id_valid, c >= 2);
      if (c >= 2) check("stream_id_pc", id_pc, 32'(4 * (c - 2)));
      tick();
    end

    // Decode stall for five cycles
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1("stall_id_valid", id_valid, 1'b1);
      check("stall_id_pc", id_pc, 32'd32);
      check1("stall_req_valid", imem_req_valid, 1'b0);
      tick();
    end
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("resume_id_valid", id_valid, 1'b1);
      check("resume_id_pc", id_pc, 32'(32 + 4 * k));
      if (k == 0) begin
        check1("resume_req_valid", imem_req_valid, 1'b1);
        check("resume_req_addr", imem_req_addr, 32'd40);
      end
      tick();
    end

    // Redirect with two requests in flight (latency 3)
    lat_min = 3; lat_max = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    @(negedge clk);
    check1("inflight_redir_req", imem_req_valid, 1'b0);
    check1("inflight_redir_id", id_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("inflight_drop1_req", imem_req_valid, 1'b0);
    tick();
    @(negedge clk);
    check1("inflight_drop2_req", imem_req_valid, 1'b0);
    tick();
    @(negedge clk);
    check1("inflight_restart_req", imem_req_valid, 1'b1);
    check("inflight_restart_addr", imem_req_addr, 32'h0000_1000);
    tick();
    wait_id("inflight_first_id_pc", 32'h0000_1000, 20);
    tick();

    // Redirect coinciding with a response and a would-be dequeue
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clk);
    check1("coinc_id_valid", id_valid, 1'b0);
    check1("coinc_req_valid", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("coinc_restart_req", imem_req_valid, 1'b1);
    check("coinc_restart_addr", imem_req_addr, 32'h0000_2000);
    tick();
    wait_id("coinc_first_id_pc", 32'h0000_2000, 10);
    tick();

    // PC wrap after redirect to the top word (low bits must be ignored)
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    check1("wrap_redir_req", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check1("wrap_req_valid", imem_req_valid, 1'b1);
    check("wrap_addr_zero", imem_req_addr, 32'h0);
    tick();
    wait_id("wrap_first_id_pc", 32'hFFFF_FFFC, 10);

    // Asynchronous reset mid-stream
    repeat (3) tick();
    #3;
    check1("async_pre_valid", id_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_id_valid", id_valid, 1'b0);
    check1("async_req_valid", imem_req_valid, 1'b0);
    check("async_id_instr", id_instruction, NOP);
    do_reset();
    @(negedge clk);
    check1("async_restart_req", imem_req_valid, 1'b1);
    check("async_restart_addr", imem_req_addr, RESET_PC);
    tick();
    wait_id("async_first_id_pc", RESET_PC, 10);
    tick();

    // Randomized traffic with variable latency, back-pressure and redirects
    lat_min = 1; lat_max = 4;
    do_reset();
    deq_before = deq_count;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ((i % 200) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    repeat (20) tick();
    check1("random_progress", (deq_count - deq_before) > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
